// File: rtl/tptx_state_timer.sv
// Transport-TX state register with dwell and link-busy watchdogs.
// The current state is loaded each cycle from the one-hot next_state vector.
// Illegal vectors fall back to IDLE and are counted.
// dwell_cnt measures time spent in the current non-IDLE state and drives expire.
// busy_cnt measures how long the link TX FSM has been busy and drives txtimeout.
module tptx_state_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] next_state,
  input  logic        tptx_reset,
  input  logic        lk_txfsmidle,
  input  logic [15:0] cfg_expire_limit,
  input  logic [15:0] cfg_txto_limit,
  output logic [14:0] cur_state,
  output logic        expire,
  output logic        txtimeout,
  output logic        state_err,
  output logic [7:0]  err_cnt
);

  localparam logic [14:0] IDLE_ST = 15'h0001;

  logic [14:0] cur_state_q, cur_state_d;
  logic [15:0] dwell_cnt_q, dwell_cnt_d;
  logic [15:0] busy_cnt_q, busy_cnt_d;
  logic        expire_q, expire_d;
  logic        txtimeout_q, txtimeout_d;
  logic        state_err_q, state_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        ns_onehot;
  logic [14:0] load_state;
  logic        state_change;
  logic        busy_active;
  logic [16:0] dwell_inc;
  logic [16:0] busy_inc;

  // Next-state computation for every register; soft reset takes priority over the legality check
  always_comb begin
    ns_onehot    = (next_state != 15'd0) && ((next_state & (next_state - 15'd1)) == 15'd0);
    load_state   = ns_onehot ? next_state : IDLE_ST;
    state_change = (load_state != cur_state_q);
    busy_active  = !lk_txfsmidle && (cur_state_q != IDLE_ST);
    // 17-bit increments so a saturated counter can never wrap onto a small limit
    dwell_inc    = {1'b0, dwell_cnt_q} + 17'd1;
    busy_inc     = {1'b0, busy_cnt_q} + 17'd1;

    cur_state_d  = cur_state_q;
    dwell_cnt_d  = dwell_cnt_q;
    busy_cnt_d   = busy_cnt_q;
    expire_d     = expire_q;
    txtimeout_d  = txtimeout_q;
    state_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (tptx_reset) begin
      cur_state_d = IDLE_ST;
      dwell_cnt_d = 16'd0;
      busy_cnt_d  = 16'd0;
      expire_d    = 1'b0;
      txtimeout_d = 1'b0;
    end else begin
      cur_state_d = load_state;
      state_err_d = !ns_onehot;
      if (!ns_onehot && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end

      // Dwell time restarts on any state change and is held at zero in IDLE
      if (state_change || (load_state == IDLE_ST)) begin
        dwell_cnt_d = 16'd0;
      end else if (dwell_cnt_q != 16'hFFFF) begin
        dwell_cnt_d = dwell_inc[15:0];
      end

      // A state change on the limit cycle wins over the expire condition
      if (state_change) begin
        expire_d = 1'b0;
      end else if (!expire_q) begin
        expire_d = (load_state != IDLE_ST) && (cfg_expire_limit != 16'd0) &&
                   (dwell_inc == {1'b0, cfg_expire_limit});
      end

      if (busy_active) begin
        busy_cnt_d  = (busy_cnt_q != 16'hFFFF) ? busy_inc[15:0] : busy_cnt_q;
        txtimeout_d = txtimeout_q ||
                      ((cfg_txto_limit != 16'd0) && (busy_inc == {1'b0, cfg_txto_limit}));
      end else begin
        busy_cnt_d  = 16'd0;
        txtimeout_d = 1'b0;
      end
    end
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state_q <= IDLE_ST;
      dwell_cnt_q <= 16'd0;
      busy_cnt_q  <= 16'd0;
      expire_q    <= 1'b0;
      txtimeout_q <= 1'b0;
      state_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      cur_state_q <= cur_state_d;
      dwell_cnt_q <= dwell_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      expire_q    <= expire_d;
      txtimeout_q <= txtimeout_d;
      state_err_q <= state_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cur_state = cur_state_q;
  assign expire    = expire_q;
  assign txtimeout = txtimeout_q;
  assign state_err = state_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
